// File: rtl/calc_seq.sv
// Sequencer for the UART calculator: collects operand/operand/operator bytes, runs the datapath, echoes bytes plus result.
// Transmit strobes wait for tx_busy low with at least one idle cycle between strobes; RX bytes arriving mid-operation are dropped.
module calc_seq #(
    parameter int DP_LAT = 1
) (
    input  logic       clk12m,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_data_rdy,
    output logic [7:0] tx_data,
    output logic       tx_data_rdy,
    input  logic       tx_busy,
    output logic [3:0] dp_a,
    output logic [3:0] dp_b,
    output logic       dp_sub,
    input  logic [4:0] dp_res,
    output logic [4:0] leds,
    output logic       err,
    output logic       drop
);

    localparam logic [3:0] LAT = 4'(DP_LAT);

    typedef enum logic [2:0] {
        IDLE, GET2, GETOP, EXEC, TX1, TX2, TX3, DONE
    } state_t;

    state_t     state;
    logic [7:0] op1_byte;
    logic [7:0] op2_byte;
    logic [3:0] cnt;
    logic       can_send;
    logic       busy_phase;

    function automatic logic [3:0] decode(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h3F)
            return b[3:0];
        else if ((b >= 8'h61 && b <= 8'h66) || (b >= 8'h41 && b <= 8'h46))
            return b[3:0] + 4'd9;
        else if (b >= 8'h50 && b <= 8'h5F)
            return b[3:0];
        else
            return 4'd0;
    endfunction

    function automatic logic [7:0] encode(input logic [4:0] r);
        return r[4] ? {4'h5, r[3:0]} : {4'h3, r[3:0]};
    endfunction

    // tx_data_rdy high means a strobe is in flight this cycle, so the next one must wait a cycle.
    assign can_send   = !tx_busy && !tx_data_rdy;
    assign busy_phase = (state == EXEC) || (state == TX1) || (state == TX2) ||
                        (state == TX3)  || (state == DONE);

    always_ff @(posedge clk12m or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op1_byte    <= 8'h00;
            op2_byte    <= 8'h00;
            cnt         <= 4'd0;
            tx_data     <= 8'h00;
            tx_data_rdy <= 1'b0;
            dp_a        <= 4'd0;
            dp_b        <= 4'd0;
            dp_sub      <= 1'b0;
            leds        <= 5'd0;
            err         <= 1'b0;
            drop        <= 1'b0;
        end else begin
            tx_data_rdy <= 1'b0;
            if (rx_data_rdy && busy_phase)
                drop <= 1'b1;
            case (state)
                IDLE: if (rx_data_rdy) begin
                    op1_byte <= rx_data;
                    drop     <= 1'b0;
                    state    <= GET2;
                end
                GET2: if (rx_data_rdy) begin
                    op2_byte <= rx_data;
                    state    <= GETOP;
                end
                GETOP: if (rx_data_rdy) begin
                    if (rx_data == 8'h2B || rx_data == 8'h2D) begin
                        dp_sub <= (rx_data == 8'h2D);
                        dp_a   <= decode(op1_byte);
                        dp_b   <= decode(op2_byte);
                        err    <= 1'b0;
                        cnt    <= 4'd1;
                        state  <= EXEC;
                    end else begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end
                end
                EXEC: begin
                    if (cnt == LAT) begin
                        leds  <= dp_res;
                        state <= TX1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                TX1: if (can_send) begin
                    tx_data     <= op1_byte;
                    tx_data_rdy <= 1'b1;
                    state       <= TX2;
                end
                TX2: if (can_send) begin
                    tx_data     <= op2_byte;
                    tx_data_rdy <= 1'b1;
                    state       <= TX3;
                end
                TX3: if (can_send) begin
                    tx_data     <= encode(leds);
                    tx_data_rdy <= 1'b1;
                    state       <= DONE;
                end
                // One-cycle tail so IDLE is entered the cycle after the final strobe.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_seq.sv
// Directed bench for calc_seq: one instance with DP_LAT=1 (vector table, busy/drop case) and one with DP_LAT=4 (latency, mid-sequence reset).
module tb_calc_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       sel;
    logic       busy1, busy4;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_bad = 0;

    logic [7:0] tx_data1, tx_data4;
    logic       tx_rdy1, tx_rdy4;
    logic [3:0] dp_a1, dp_b1, dp_a4, dp_b4;
    logic       dp_sub1, dp_sub4;
    logic [4:0] dp_res1, dp_res4;
    logic [4:0] leds1, leds4;
    logic       err1, err4, drop1, drop4;
    logic       rx_rdy1, rx_rdy4;
    logic [4:0] p1, p2, p3;

    int         q1_cyc[$], q4_cyc[$];
    logic [7:0] q1_dat[$], q4_dat[$];

    assign rx_rdy1 = rx_rdy && !sel;
    assign rx_rdy4 = rx_rdy && sel;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4:0] alu(input logic [3:0] a, input logic [3:0] b, input logic s);
        return s ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    endfunction

    // Datapath models: combinational for latency 1, three registers for latency 4.
    assign dp_res1 = alu(dp_a1, dp_b1, dp_sub1);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1 <= 5'd0; p2 <= 5'd0; p3 <= 5'd0;
        end else begin
            p1 <= alu(dp_a4, dp_b4, dp_sub4); p2 <= p1; p3 <= p2;
        end
    end
    assign dp_res4 = p3;

    always @(negedge clk) begin
        if (tx_rdy1) begin q1_cyc.push_back(cyc); q1_dat.push_back(tx_data1); end
        if (tx_rdy4) begin q4_cyc.push_back(cyc); q4_dat.push_back(tx_data4); end
    end

    calc_seq #(.DP_LAT(1)) dut1 (
        .clk12m(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_data_rdy(rx_rdy1),
        .tx_data(tx_data1), .tx_data_rdy(tx_rdy1), .tx_busy(busy1),
        .dp_a(dp_a1), .dp_b(dp_b1), .dp_sub(dp_sub1), .dp_res(dp_res1),
        .leds(leds1), .err(err1), .drop(drop1)
    );

    calc_seq #(.DP_LAT(4)) dut4 (
        .clk12m(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_data_rdy(rx_rdy4),
        .tx_data(tx_data4), .tx_data_rdy(tx_rdy4), .tx_busy(busy4),
        .dp_a(dp_a4), .dp_b(dp_b4), .dp_sub(dp_sub4), .dp_res(dp_res4),
        .leds(leds4), .err(err4), .drop(drop4)
    );

    function automatic int qsize(input bit w);
        return w ? q4_dat.size() : q1_dat.size();
    endfunction
    function automatic logic [7:0] qdat(input bit w, input int i);
        return w ? q4_dat[i] : q1_dat[i];
    endfunction
    function automatic int qcyc(input bit w, input int i);
        return w ? q4_cyc[i] : q1_cyc[i];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns the cycle index of the edge that sampled the operator.
    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] o, output int opcyc);
        rx_data = a; rx_rdy = 1'b1;
        @(negedge clk); rx_data = b;
        @(negedge clk); rx_data = o;
        @(negedge clk); rx_rdy = 1'b0;
        opcyc = cyc;
    endtask

    task automatic check_seq(input bit w, input int base, input int opcyc, input int lat,
                             input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3,
                             input string tag);
        int t = 0;
        while (qsize(w) - base < 3 && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk({tag, " strobe count"}, qsize(w) - base, 3);
        if (qsize(w) - base >= 3) begin
            chk({tag, " byte1"}, qdat(w, base), e1);
            chk({tag, " byte2"}, qdat(w, base + 1), e2);
            chk({tag, " byte3"}, qdat(w, base + 2), e3);
            if (lat > 0) begin
                chk({tag, " first strobe latency"}, qcyc(w, base) - opcyc, lat + 1);
                chk({tag, " gap12"}, qcyc(w, base + 1) - qcyc(w, base), 2);
                chk({tag, " gap23"}, qcyc(w, base + 2) - qcyc(w, base + 1), 2);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] c1, c2, op;
        bit         ok;
        logic [3:0] a, b;
        logic [7:0] enc;
        logic [4:0] leds;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int  n, base, t;
        bit  seen;
        string tag;

        tbl[0]  = '{8'h30, 8'h34, 8'h2B, 1'b1, 4'h0, 4'h4, 8'h34, 5'h04};
        tbl[1]  = '{8'h35, 8'h32, 8'h2D, 1'b1, 4'h5, 4'h2, 8'h33, 5'h03};
        tbl[2]  = '{8'h32, 8'h33, 8'h2D, 1'b1, 4'h2, 4'h3, 8'h5F, 5'h1F};
        tbl[3]  = '{8'h66, 8'h31, 8'h2B, 1'b1, 4'hF, 4'h1, 8'h50, 5'h10};
        tbl[4]  = '{8'h46, 8'h46, 8'h2B, 1'b1, 4'hF, 4'hF, 8'h5E, 5'h1E};
        tbl[5]  = '{8'h31, 8'h32, 8'h2A, 1'b0, 4'h0, 4'h0, 8'h00, 5'h1E};
        tbl[6]  = '{8'h31, 8'h32, 8'h2B, 1'b1, 4'h1, 4'h2, 8'h33, 5'h03};
        tbl[7]  = '{8'h50, 8'h61, 8'h2B, 1'b1, 4'h0, 4'hA, 8'h3A, 5'h0A};
        tbl[8]  = '{8'h5A, 8'h67, 8'h2D, 1'b1, 4'hA, 4'h0, 8'h3A, 5'h0A};
        tbl[9]  = '{8'h39, 8'h3F, 8'h2B, 1'b1, 4'h9, 4'hF, 8'h58, 5'h18};
        tbl[10] = '{8'h43, 8'h40, 8'h2D, 1'b1, 4'hC, 4'h0, 8'h3C, 5'h0C};

        rst_n = 1'b0; rx_data = 8'h00; rx_rdy = 1'b0; sel = 1'b0; busy1 = 1'b0; busy4 = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset tx_data", tx_data1, 8'h00);
        chk("reset tx_data_rdy", tx_rdy1, 1'b0);
        chk("reset dp_a", dp_a1, 4'h0);
        chk("reset dp_b", dp_b1, 4'h0);
        chk("reset dp_sub", dp_sub1, 1'b0);
        chk("reset leds", leds1, 5'h00);
        chk("reset err", err1, 1'b0);
        chk("reset drop", drop1, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Transmitter busy through TX1, then a stray byte injected while in TX2.
        base = q1_dat.size();
        send3(8'h33, 8'h34, 8'h2B, n);
        busy1 = 1'b1;
        repeat (20) @(negedge clk);
        chk("busy no strobe", q1_dat.size() - base, 0);
        busy1 = 1'b0;
        seen = 1'b0;
        t = 0;
        while (!seen && t < 10) begin
            @(negedge clk);
            seen = tx_rdy1;
            t++;
        end
        chk("busy first strobe seen", seen, 1'b1);
        busy1 = 1'b1; rx_data = 8'h39; rx_rdy = 1'b1;
        @(negedge clk); rx_rdy = 1'b0;
        repeat (3) @(negedge clk);
        busy1 = 1'b0;
        check_seq(1'b0, base, n, -1, 8'h33, 8'h34, 8'h37, "busy");
        chk("busy drop", drop1, 1'b1);
        chk("busy leds", leds1, 5'h07);
        chk("busy err", err1, 1'b0);

        for (int i = 0; i < 11; i++) begin
            tag = $sformatf("v%0d", i);
            base = q1_dat.size();
            send3(tbl[i].c1, tbl[i].c2, tbl[i].op, n);
            if (tbl[i].ok) begin
                check_seq(1'b0, base, n, 1, tbl[i].c1, tbl[i].c2, tbl[i].enc, tag);
                chk({tag, " dp_a"}, dp_a1, tbl[i].a);
                chk({tag, " dp_b"}, dp_b1, tbl[i].b);
                chk({tag, " dp_sub"}, dp_sub1, tbl[i].op == 8'h2D);
            end else begin
                repeat (12) @(negedge clk);
                chk({tag, " no strobe"}, q1_dat.size() - base, 0);
            end
            chk({tag, " leds"}, leds1, tbl[i].leds);
            chk({tag, " err"}, err1, !tbl[i].ok);
            chk({tag, " drop"}, drop1, 1'b0);
        end

        // Latency-4 instance: leds must change exactly at the fourth edge after the operator.
        sel = 1'b1;
        base = q4_dat.size();
        send3(8'h37, 8'h39, 8'h2B, n);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 3) chk("lat4 leds before sample", leds4, 5'h00);
            if (k == 4) chk("lat4 leds at sample", leds4, 5'h10);
            if (k == 5) begin
                chk("lat4 first strobe", tx_rdy4, 1'b1);
                chk("lat4 first byte", tx_data4, 8'h37);
            end
        end
        rst_n = 1'b0;
        @(negedge clk);
        base = q4_dat.size();
        @(negedge clk);
        chk("rst4 tx_data", tx_data4, 8'h00);
        chk("rst4 tx_data_rdy", tx_rdy4, 1'b0);
        chk("rst4 dp_a", dp_a4, 4'h0);
        chk("rst4 dp_b", dp_b4, 4'h0);
        chk("rst4 dp_sub", dp_sub4, 1'b0);
        chk("rst4 leds", leds4, 5'h00);
        chk("rst4 err", err4, 1'b0);
        chk("rst4 drop", drop4, 1'b0);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("rst4 no further strobes", q4_dat.size() - base, 0);

        base = q4_dat.size();
        send3(8'h33, 8'h33, 8'h2D, n);
        check_seq(1'b1, base, n, 4, 8'h33, 8'h33, 8'h30, "lat4");
        chk("lat4 leds", leds4, 5'h00);
        chk("lat4 err", err4, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/calc_seq.md
# calc_seq

UART-fed sequencer for the 4-bit add/subtract calculator. Collects three received ASCII bytes (operand 1, operand 2, operator), decodes the operands, drives the external adder/subtractor datapath, waits its latency, and then sends operand 1, operand 2 and the ASCII-encoded 5-bit result to the UART transmitter. It also drives the five status LEDs with the result. It sits between the UART RX/TX blocks and the arithmetic datapath in the top level.

## Interface
- `DP_LAT`, default 1: cycles from datapath operands being valid to `dp_res` being valid; range 1–15.
- `clk12m` in, 1: system clock, 12 MHz.
- `rst_n` in, 1: asynchronous reset, active-low.
- `rx_data` in, 8: received byte.
- `rx_data_rdy` in, 1: single-cycle strobe marking `rx_data` valid.
- `tx_data` out, 8: byte to transmit.
- `tx_data_rdy` out, 1: single-cycle strobe marking `tx_data` valid.
- `tx_busy` in, 1: transmitter busy; a byte is never strobed while it is high.
- `dp_a` out, 4: operand 1 to the datapath.
- `dp_b` out, 4: operand 2 to the datapath.
- `dp_sub` out, 1: 1 = subtract, 0 = add.
- `dp_res` in, 5: datapath result {carry/borrow, sum}, modulo 32.
- `leds` out, 5: last result.
- `err` out, 1: sticky flag for a bad operator byte.
- `drop` out, 1: sticky flag for an RX byte received while busy.

## Operation
- Operand decode, on the low nibble:
  - 0x30–0x3F → byte − 0x30.
  - 0x61–0x66 ('a'–'f') → 10–15.
  - 0x41–0x46 → 10–15.
  - 0x50–0x5F → byte − 0x50.
  - Any other byte → 0.
- Operator decode: '+' (0x2B) → add; '-' (0x2D) → subtract. Any other byte is invalid.
- Result encoding: `enc = res[4] ? 8'h50 + res[3:0] : 8'h30 + res[3:0]`.
- State machine:
  - **IDLE**: an rx strobe latches operand-1 byte → GET2.
  - **GET2**: an rx strobe latches operand-2 byte → GETOP.
  - **GETOP**: an rx strobe arrives.
    - Valid operator: latch `dp_sub`, drive `dp_a`/`dp_b`, clear `err` → EXEC.
    - Invalid operator: set `err`, send nothing → IDLE.
  - **EXEC**: count DP_LAT cycles. On the last count, register `dp_res` into `res` and `leds` → TX1.
  - **TX1 / TX2 / TX3**: send the operand-1 byte as received, the operand-2 byte as received, then `enc`. TX3 → IDLE.
- Transmit rule in each TX state: strobe `tx_data_rdy` for exactly one cycle, on the first cycle where `tx_busy` = 0 and at least one cycle has passed since the previous strobe; then advance.
- Bytes received in EXEC or any TX state are discarded and set `drop`. The sequence is not disturbed.
- `drop` clears when the next operation starts, i.e. on the operand-1 strobe in IDLE.
- `dp_a`, `dp_b` and `dp_sub` hold stable from entry to EXEC until the next GETOP acceptance.
- Reset mid-operation, at any state: immediate return to IDLE. A partially sent sequence is abandoned, with no further strobes.

## Timing
- Reset values: `tx_data` = 0x00, `tx_data_rdy` = 0, `dp_a` = 0, `dp_b` = 0, `dp_sub` = 0, `leds` = 0, `err` = 0, `drop` = 0; state IDLE.
- All outputs are registered.
- `rx_data_rdy` is sampled on the rising edge of `clk12m`. Back-to-back strobes on consecutive cycles are all accepted in IDLE/GET2/GETOP.
- The operator strobe at edge N enters EXEC with `dp_*` valid after edge N. `dp_res` is sampled at edge N+DP_LAT, and `leds` update at that same edge.
- With `tx_busy` held low:
  - first `tx_data_rdy` is high during the cycle after edge N+DP_LAT+1;
  - strobes are spaced 2 cycles apart;
  - IDLE is re-entered one cycle after the third strobe.
- `tx_busy` rising in the same cycle a strobe is issued does not cancel that strobe.
- An rx strobe in the same cycle the FSM returns from TX3 to IDLE is dropped; IDLE accepts from the next cycle.

## Test plan
- Send "0","4","+", `tx_busy` = 0, DP_LAT = 1, bench adder model → TX "0","4","4"; `leds` = 00100; `err` = 0.
- Send "5","2","-" → TX "5","2","3"; `leds` = 00011. Then "2","3","-" → third byte '_' (0x5F); `leds` = 11111.
- Send "f","1","+" → third byte 'P' (0x50), `leds` = 10000. Send "F","F","+" → third byte '^' (0x5E), `leds` = 11110.
- Send "1","2","*" → no `tx_data_rdy` at all; `err` = 1. Then "1","2","+" → `err` clears on the operator edge; TX "1","2","3".
- Hold `tx_busy` high for 20 cycles after EXEC, and inject an rx byte during TX2 → no strobe while busy; three strobes in order once it clears; `drop` = 1; `leds` unchanged by the dropped byte.
- With DP_LAT = 4, send "7","9","+" and assert `rst_n` low between the first and second strobe → `dp_res` is sampled exactly 4 cycles after the operator edge; after reset all outputs are at reset values and no further strobes occur; a following "3","3","-" yields TX "3","3","0".
